// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: operation codes, FSM states and
// the decode helper that splits base operations from multiply/divide.
package alu_pkg;

    typedef enum logic [4:0] {
        OP_AND    = 5'b00000,
        OP_OR     = 5'b00001,
        OP_ADD    = 5'b00010,
        OP_SLTU   = 5'b00011,
        OP_SUB    = 5'b00110,
        OP_SLT    = 5'b00111,
        OP_XOR    = 5'b01000,
        OP_SLL    = 5'b01001,
        OP_SRL    = 5'b01010,
        OP_SRA    = 5'b01011,
        OP_MUL    = 5'b10000,
        OP_MULH   = 5'b10001,
        OP_MULHSU = 5'b10010,
        OP_MULHU  = 5'b10011,
        OP_DIV    = 5'b10100,
        OP_DIVU   = 5'b10101,
        OP_REM    = 5'b10110,
        OP_REMU   = 5'b10111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } alu_state_e;

    function automatic logic is_muldiv(input logic [4:0] op);
        return op[4];
    endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, sign fix-up folded into the last step.
module seq_muldiv #(
    parameter int XLEN = 32,
    localparam int SHW = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            abort,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    logic            run_q,   run_d;
    logic [SHW-1:0]  cnt_q,   cnt_d;
    logic [XLEN-1:0] acc_q,   acc_d;
    logic [XLEN-1:0] lo_q,    lo_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [2:0]      op_q,    op_d;
    logic            neg_q,   neg_d;
    logic            dz_q,    dz_d;

    logic            is_div_s, sgn_a_s, sgn_b_s, neg_a_s, neg_b_s;
    logic [XLEN-1:0] mag_a_s, mag_b_s;
    logic [XLEN:0]   mul_sum_s;
    logic [XLEN:0]   div_shift_s;
    logic [XLEN+1:0] div_diff_s;
    logic [XLEN-1:0] step_acc_s, step_lo_s;
    logic [2*XLEN-1:0] prod_s, prod_fix_s;

    // Operand conditioning at start: signedness per op and magnitudes.
    always_comb begin
        is_div_s = op[2];
        if (is_div_s) begin
            sgn_a_s = ~op[0];
            sgn_b_s = ~op[0];
        end else begin
            sgn_a_s = (op[1:0] != 2'b11);
            sgn_b_s = ~op[1];
        end
        neg_a_s = sgn_a_s & operand_a[XLEN-1];
        neg_b_s = sgn_b_s & operand_b[XLEN-1];
        mag_a_s = neg_a_s ? (-operand_a) : operand_a;
        mag_b_s = neg_b_s ? (-operand_b) : operand_b;
    end

    // One iteration of the shared datapath; acc holds product-high or remainder.
    always_comb begin
        mul_sum_s   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
        div_shift_s = {acc_q, lo_q[XLEN-1]};
        div_diff_s  = {1'b0, div_shift_s} - {2'b00, mcand_q};
        if (op_q[2]) begin
            if (!div_diff_s[XLEN+1]) begin
                step_acc_s = div_diff_s[XLEN-1:0];
                step_lo_s  = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                step_acc_s = div_shift_s[XLEN-1:0];
                step_lo_s  = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            step_acc_s = mul_sum_s[XLEN:1];
            step_lo_s  = {mul_sum_s[0], lo_q[XLEN-1:1]};
        end
    end

    // Sign fix-up applied to the post-step value so the final edge writes it.
    always_comb begin
        prod_s     = {step_acc_s, step_lo_s};
        prod_fix_s = neg_q ? (-prod_s) : prod_s;
        case (op_q)
            3'b000:                 result = prod_fix_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: result = prod_fix_s[2*XLEN-1:XLEN];
            // Divide by zero forces an all-ones quotient regardless of signs.
            3'b100, 3'b101:         result = dz_q ? {XLEN{1'b1}} : (neg_q ? (-step_lo_s) : step_lo_s);
            3'b110, 3'b111:         result = neg_q ? (-step_acc_s) : step_acc_s;
            default:                result = {XLEN{1'b0}};
        endcase
    end

    assign done = run_q && (cnt_q == {SHW{1'b0}});

    // Next-state: abort wins, then load on start, then iterate while running.
    always_comb begin
        run_d   = run_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        mcand_d = mcand_q;
        op_d    = op_q;
        neg_d   = neg_q;
        dz_d    = dz_q;
        if (abort) begin
            run_d = 1'b0;
            cnt_d = {SHW{1'b0}};
        end else if (start) begin
            run_d = 1'b1;
            cnt_d = SHW'(XLEN - 1);
            acc_d = {XLEN{1'b0}};
            op_d  = op;
            if (is_div_s) begin
                lo_d    = mag_a_s;
                mcand_d = mag_b_s;
                neg_d   = op[1] ? neg_a_s : (neg_a_s ^ neg_b_s);
                dz_d    = (operand_b == {XLEN{1'b0}});
            end else begin
                lo_d    = mag_b_s;
                mcand_d = mag_a_s;
                neg_d   = neg_a_s ^ neg_b_s;
                dz_d    = 1'b0;
            end
        end else if (run_q) begin
            acc_d = step_acc_s;
            lo_d  = step_lo_s;
            if (cnt_q == {SHW{1'b0}}) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - SHW'(1);
            end
        end else begin
            run_d = 1'b0;
        end
    end

    // Datapath and control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q   <= 1'b0;
            cnt_q   <= {SHW{1'b0}};
            acc_q   <= {XLEN{1'b0}};
            lo_q    <= {XLEN{1'b0}};
            mcand_q <= {XLEN{1'b0}};
            op_q    <= 3'b000;
            neg_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            run_q   <= run_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            mcand_q <= mcand_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            dz_q    <= dz_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked sequential ALU: single-cycle base ops, iterative M ops via
// seq_muldiv, registered result held until the consumer accepts it.
module seq_alu #(
    parameter int XLEN = 32,
    localparam int SHW = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);
    import alu_pkg::*;

    alu_state_e      state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic [XLEN-1:0] base_res_s, md_result_s;
    logic [SHW-1:0]  shamt_s;
    logic            md_start_s, md_done_s;

    seq_muldiv #(.XLEN(XLEN)) u_muldiv (
        .clk       (clk),
        .rst_n     (rst_n),
        .abort     (flush),
        .start     (md_start_s),
        .op        (op[2:0]),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .done      (md_done_s),
        .result    (md_result_s)
    );

    // Base-op result; undefined codes yield zero.
    always_comb begin
        shamt_s = operand_b[SHW-1:0];
        case (op)
            OP_ADD:  base_res_s = operand_a + operand_b;
            OP_SUB:  base_res_s = operand_a - operand_b;
            OP_XOR:  base_res_s = operand_a ^ operand_b;
            OP_OR:   base_res_s = operand_a | operand_b;
            OP_AND:  base_res_s = operand_a & operand_b;
            OP_SLL:  base_res_s = operand_a << shamt_s;
            OP_SRL:  base_res_s = operand_a >> shamt_s;
            OP_SRA:  base_res_s = $signed(operand_a) >>> shamt_s;
            OP_SLT:  base_res_s = {{(XLEN-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
            OP_SLTU: base_res_s = {{(XLEN-1){1'b0}}, (operand_a < operand_b)};
            default: base_res_s = {XLEN{1'b0}};
        endcase
    end

    // FSM next-state and result capture; flush returns to a clean idle.
    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        zero_d     = zero_q;
        md_start_s = 1'b0;
        if (flush) begin
            state_d  = ST_IDLE;
            result_d = {XLEN{1'b0}};
            zero_d   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && is_muldiv(op)) begin
                        md_start_s = 1'b1;
                        state_d    = ST_BUSY;
                    end else if (in_valid) begin
                        result_d = base_res_s;
                        zero_d   = (base_res_s == {XLEN{1'b0}});
                        state_d  = ST_DONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (md_done_s) begin
                        result_d = md_result_s;
                        zero_d   = (md_result_s == {XLEN{1'b0}});
                        state_d  = ST_DONE;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    result_d = {XLEN{1'b0}};
                    zero_d   = 1'b1;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= {XLEN{1'b0}};
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (XLEN = 32).
module tb_seq_alu;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    int checks = 0;
    int errors = 0;

    seq_alu #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op with out_ready high, check latency/result/zero, then return to idle.
    task automatic run_op(input string tag, input logic [4:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int exp_cyc, input logic [31:0] exp_res,
                          input logic exp_zero);
        int cyc;
        op = o; operand_a = a; operand_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; op = 5'b00010; operand_a = 32'hDEADBEEF; operand_b = 32'h12345678;
        cyc = 1;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, " latency"}, 32'(cyc), 32'(exp_cyc));
        chk({tag, " result"}, result, exp_res);
        chk({tag, " zero"}, {31'd0, zero}, {31'd0, exp_zero});
        @(posedge clk); #1;
        chk({tag, " in_ready after"}, {31'd0, in_ready}, 32'd1);
        chk({tag, " out_valid after"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        logic seen;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; op = 5'd0;
        operand_a = 32'd0; operand_b = 32'd0; out_ready = 1'b1;
        #12;
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset zero", {31'd0, zero}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("ADD ovf", 5'b00010, 32'h7FFFFFFF, 32'h00000001, 1, 32'h80000000, 1'b0);
        run_op("UNDEF",   5'b01111, 32'h00000005, 32'h00000006, 1, 32'h00000000, 1'b1);
        run_op("SUB",     5'b00110, 32'h00000005, 32'h00000005, 1, 32'h00000000, 1'b1);
        run_op("SRA",     5'b01011, 32'h80000000, 32'h00000024, 1, 32'hF8000000, 1'b0);
        run_op("SRL",     5'b01010, 32'h80000000, 32'h00000024, 1, 32'h08000000, 1'b0);
        run_op("SLL",     5'b01001, 32'h00000001, 32'h0000001F, 1, 32'h80000000, 1'b0);
        run_op("SLTU",    5'b00011, 32'hFFFFFFFF, 32'h00000001, 1, 32'h00000000, 1'b1);
        run_op("SLT",     5'b00111, 32'hFFFFFFFF, 32'h00000001, 1, 32'h00000001, 1'b0);
        run_op("XOR",     5'b01000, 32'hF0F0F0F0, 32'hFF00FF00, 1, 32'h0FF00FF0, 1'b0);
        run_op("OR",      5'b00001, 32'hF0F0F0F0, 32'hFF00FF00, 1, 32'hFFF0FFF0, 1'b0);
        run_op("AND",     5'b00000, 32'hF0F0F0F0, 32'hFF00FF00, 1, 32'hF000F000, 1'b0);

        run_op("MULH",    5'b10001, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'h00000000, 1'b1);
        run_op("MULHU",   5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE, 1'b0);
        run_op("MUL",     5'b10000, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'h00000001, 1'b0);
        run_op("MULHSU",  5'b10010, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFF, 1'b0);
        run_op("MUL 7x6", 5'b10000, 32'h00000007, 32'hFFFFFFFA, 33, 32'hFFFFFFD6, 1'b0);

        run_op("DIV ovf", 5'b10100, 32'h80000000, 32'hFFFFFFFF, 33, 32'h80000000, 1'b0);
        run_op("REM ovf", 5'b10110, 32'h80000000, 32'hFFFFFFFF, 33, 32'h00000000, 1'b1);
        run_op("DIVU /0", 5'b10101, 32'h00000007, 32'h00000000, 33, 32'hFFFFFFFF, 1'b0);
        run_op("REMU /0", 5'b10111, 32'h00000007, 32'h00000000, 33, 32'h00000007, 1'b0);
        run_op("DIV -7/2", 5'b10100, 32'hFFFFFFF9, 32'h00000002, 33, 32'hFFFFFFFD, 1'b0);
        run_op("REM -7/2", 5'b10110, 32'hFFFFFFF9, 32'h00000002, 33, 32'hFFFFFFFF, 1'b0);
        run_op("DIV -5/0", 5'b10100, 32'hFFFFFFFB, 32'h00000000, 33, 32'hFFFFFFFF, 1'b0);
        run_op("REM -5/0", 5'b10110, 32'hFFFFFFFB, 32'h00000000, 33, 32'hFFFFFFFB, 1'b0);

        // Backpressure: hold the result while a competing request waits.
        out_ready = 1'b0;
        op = 5'b00010; operand_a = 32'd3; operand_b = 32'd4; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("bp out_valid", {31'd0, out_valid}, 32'd1);
        operand_a = 32'd100; operand_b = 32'd1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp result", result, 32'd7);
            chk("bp in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp out_valid hold", {31'd0, out_valid}, 32'd1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp release in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp release out_valid", {31'd0, out_valid}, 32'd0);
        chk("bp release result", result, 32'd7);

        // Flush in IDLE drops a simultaneous request.
        op = 5'b00010; operand_a = 32'd1; operand_b = 32'd1; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("idle flush in_ready", {31'd0, in_ready}, 32'd1);
        chk("idle flush out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        chk("idle flush no accept", {31'd0, out_valid}, 32'd0);

        // Flush at BUSY cycle 10.
        run_op("pre-flush ADD", 5'b00010, 32'd1, 32'd2, 1, 32'd3, 1'b0);
        op = 5'b10100; operand_a = 32'd100; operand_b = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush in_ready", {31'd0, in_ready}, 32'd1);
        chk("flush out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush result", result, 32'd0);
        chk("flush zero", {31'd0, zero}, 32'd1);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("flush never valid", {31'd0, seen}, 32'd0);

        // Asynchronous reset at BUSY cycle 5 of a fresh DIV.
        run_op("pre-reset ADD", 5'b00010, 32'd2, 32'd3, 1, 32'd5, 1'b0);
        op = 5'b10100; operand_a = 32'hFFFFFFF9; operand_b = 32'd2; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst result", result, 32'd0);
        chk("rst zero", {31'd0, zero}, 32'd1);
        #1 rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("rst never valid", {31'd0, seen}, 32'd0);
        chk("rst idle result", result, 32'd0);

        run_op("post-reset DIVU", 5'b10101, 32'd100, 32'd7, 33, 32'd14, 1'b0);
        run_op("post-reset REMU", 5'b10111, 32'd100, 32'd7, 33, 32'd2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, handshaked successor to the single-cycle ALU. It executes the base RV32I integer operations with one-cycle registered latency, and the RV32M multiply/divide operations on an iterative XLEN-cycle datapath. It sits between the decode/issue stage and writeback, and stalls issue through a valid/ready handshake on both sides.

## Interface
- `XLEN`, default 32: operand/result width; must be a power of two, ≥ 8.
- `SHW`, default $clog2(XLEN): shift-amount width (derived, not overridden).
- `clk` in, 1: single clock, rising edge.
- `rst_n` in, 1: reset, asynchronous assert, active-low.
- `flush` in, 1: synchronous cancel of any in-flight operation.
- `in_valid` in, 1: operation request.
- `in_ready` out, 1: block can accept a request.
- `op` in, 5: `alu_op_e` operation code.
- `operand_a` in, XLEN: rs1 value.
- `operand_b` in, XLEN: rs2 value or immediate.
- `out_valid` out, 1: result available.
- `out_ready` in, 1: consumer takes the result.
- `result` out, XLEN: registered result.
- `zero` out, 1: registered (`result == 0`).

## Operation
- Op codes for the base operations, `op[4] = 0`:
  - ADD 00010, SUB 00110, XOR 01000, OR 00001, AND 00000.
  - SLL 01001, SRL 01010, SRA 01011.
  - SLT 00111, SLTU 00011.
- Op codes for the M operations, `op[4] = 1`:
  - MUL 10000, MULH 10001, MULHSU 10010, MULHU 10011.
  - DIV 10100, DIVU 10101, REM 10110, REMU 10111.
- Any undefined code completes as a base op with `result = 0` and `zero = 1`.
- Shifts use only `operand_b[SHW-1:0]`. SRA is arithmetic. SLT compares signed, SLTU compares unsigned; both return 1 or 0.
- Multiply: shift-add over the operand magnitudes, with a 2·XLEN product.
  - MUL returns the low XLEN bits.
  - MULH returns the high XLEN bits, signed×signed.
  - MULHSU returns the high XLEN bits, signed×unsigned.
  - MULHU returns the high XLEN bits, unsigned×unsigned.
  - Sign correction is applied at completion.
- Divide: restoring division, one quotient bit per cycle, on magnitudes.
  - The quotient is negated when the operand signs differ.
  - The remainder takes the dividend's sign.
- Divide special cases (RISC-V semantics):
  - Divisor = 0: quotient = all ones, remainder = `operand_a`.
  - Signed overflow (MIN ÷ −1): quotient = MIN, remainder = 0.
  - Both cases still take the full XLEN iterations, so latency is fixed.
- FSM states:
  - IDLE: `in_ready = 1`. Accepts on `in_valid`. Base op goes to DONE; M op loads the iterative unit and goes to BUSY.
  - BUSY: the iteration counter counts XLEN−1 down to 0. At 0 the final result is written and the FSM goes to DONE.
  - DONE: `out_valid = 1` with `result`/`zero` held stable. Goes to IDLE when `out_ready = 1`.
- `in_ready` is high only in IDLE. There is no overlap and no bypass.
- `flush` in any state forces IDLE at the next edge.
  - Clears `out_valid` and abandons the operation.
  - Flush with `in_valid` in IDLE: the request is dropped.
- Reset values: IDLE, `out_valid = 0`, `result = 0`, `zero = 1`, counter = 0, `in_ready = 1` (combinational from state).
- Reset mid-BUSY or mid-DONE discards the operation. No partial result is ever presented.

## Timing
- Base op accepted at edge N: `out_valid` is high from N+1.
- M op accepted at edge N: `out_valid` is high from N+XLEN+1 (XLEN BUSY cycles). This is data-independent.
- Result is consumed on the edge where `out_valid && out_ready`. The next request can be accepted one edge later, so peak base-op throughput is 1 per 2 cycles.
- Outputs are registered. The only combinational paths are state to `in_ready`, and state to `out_valid`.
- `operand_a`, `operand_b` and `op` are sampled only at the accept edge. Later changes have no effect.

## Structure
- Package `alu_pkg`:
  - `alu_op_e` (5-bit enum of all codes above).
  - `alu_state_e` (IDLE/BUSY/DONE).
  - Helper `is_muldiv(op)`.
- Sub-module `seq_muldiv`:
  - Contains the iterative multiply/divide datapath, counter and sign fix-up.
  - Interface: `start`, `op`, operands in; `done` pulse and XLEN result out.
  - `seq_alu` owns the FSM, the handshake and the base-op logic.

## Test plan
- ADD 0x7FFFFFFF + 1, `out_ready` held high → `out_valid` at cycle 1, `result = 0x80000000`, `zero = 0`. SUB 5 − 5 → `result = 0`, `zero = 1`.
- SRA 0x80000000 by `operand_b = 0x24` (uses 4) → `0xF8000000`. SLTU 0xFFFFFFFF vs 1 → 0; SLT → 1.
- MULH 0xFFFFFFFF × 0xFFFFFFFF → 0x00000000; MULHU same operands → 0xFFFFFFFE; MUL → 1. Each with `out_valid` exactly 33 cycles after accept.
- DIV 0x80000000 ÷ 0xFFFFFFFF → 0x80000000; REM → 0. DIVU 7 ÷ 0 → 0xFFFFFFFF; REMU 7 ÷ 0 → 7. DIV −7 ÷ 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF.
- Backpressure: `out_ready = 0` for 10 cycles after `out_valid` → `result` stable, `in_ready = 0`, and a new `in_valid` is not accepted. Release → IDLE next cycle.
- `flush` at BUSY cycle 10, then `rst_n` low at BUSY cycle 5 of a fresh DIV → both give `out_valid` never asserted, `result = 0`, `zero = 1`, `in_ready = 1` immediately after.
